multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I core datapath: PC, IR, register file, ALU, immediate generator and data memory port.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives all enables and mux selects, including the immediate-format select consumed by the immediate generator.
- Handshakes with instruction and data memory, which have variable latency.

---
 rtl/ctrl_pkg.sv | 54 +++++
 rtl/opcode_decoder.sv | 30 +++
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the multi-cycle RV32I controller
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_type_t;

  typedef enum logic [3:0] {
    C_ILLEGAL = 4'd0,
    C_OP      = 4'd1,
    C_OP_IMM  = 4'd2,
    C_LOAD    = 4'd3,
    C_STORE   = 4'd4,
    C_BRANCH  = 4'd5,
    C_JAL     = 4'd6,
    C_JALR    = 4'd7,
    C_LUI     = 4'd8,
    C_AUIPC   = 4'd9
  } inst_class_t;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/opcode_decoder.sv
// rtl/opcode_decoder.sv - opcode to immediate format, instruction class and legality
module opcode_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  output imm_type_t   imm_type,
  output inst_class_t inst_class,
  output logic        legal
);

  // pure table lookup; anything not in RV32I base set is illegal
  always_comb begin
    imm_type   = IMM_NONE;
    inst_class = C_ILLEGAL;
    legal      = 1'b1;
    case (opcode)
      OP:      begin imm_type = IMM_NONE; inst_class = C_OP;     end
      OP_IMM:  begin imm_type = IMM_I;    inst_class = C_OP_IMM; end
      LOAD:    begin imm_type = IMM_I;    inst_class = C_LOAD;   end
      STORE:   begin imm_type = IMM_S;    inst_class = C_STORE;  end
      BRANCH:  begin imm_type = IMM_B;    inst_class = C_BRANCH; end
      JAL:     begin imm_type = IMM_J;    inst_class = C_JAL;    end
      JALR:    begin imm_type = IMM_I;    inst_class = C_JALR;   end
      LUI:     begin imm_type = IMM_U;    inst_class = C_LUI;    end
      AUIPC:   begin imm_type = IMM_U;    inst_class = C_AUIPC;  end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I sequencer; MULTICYCLE_CTRL_PERF_EN adds cycle/retire counters
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruction,
  input  logic        IMemReady,
  input  logic        DMemReady,
  input  logic        BranchTaken,
  output logic        IMemReq,
  output logic        IrWrite,
  output logic        PcWrite,
  output logic        PcInit,
  output logic [1:0]  PcSrc,
  output logic        AluSrcA,
  output logic        AluSrcB,
  output imm_type_t   ImmType,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic        RegWrite,
  output logic [1:0]  WbSel,
  output logic        Halt,
  output logic [2:0]  State
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] CycleCnt,
  output logic [31:0] InstRetCnt
`endif
);

  state_t      state;
  imm_type_t   dec_imm;
  inst_class_t inst_class;
  logic        legal;
  logic        alu_a;
  logic        alu_b;

  // RESET_PC and the upper IR bits belong to the datapath, not to sequencing
  logic unused_ok;
  assign unused_ok = ^{Instruction[31:7], RESET_PC};

  opcode_decoder u_dec (
    .opcode     (Instruction[6:0]),
    .imm_type   (dec_imm),
    .inst_class (inst_class),
    .legal      (legal)
  );

  // ALU operand selects per instruction class, held from EXEC to the end
  always_comb begin
    alu_a = 1'b0;
    alu_b = 1'b0;
    case (inst_class)
      C_OP_IMM, C_LOAD, C_STORE, C_JALR, C_LUI: alu_b = 1'b1;
      C_AUIPC: begin alu_a = 1'b1; alu_b = 1'b1; end
      default: ;
    endcase
  end

  // state sequencing; memory ready inputs only matter in their request state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  if (IMemReady) state <= S_DECODE;
        S_DECODE: state <= legal ? S_EXEC : S_HALT;
        S_EXEC: begin
          case (inst_class)
            C_LOAD, C_STORE: state <= S_MEM;
            C_BRANCH:        state <= S_FETCH;
            C_OP, C_OP_IMM, C_JAL, C_JALR, C_LUI, C_AUIPC: state <= S_WB;
            default:         state <= S_HALT;
          endcase
        end
        S_MEM:    if (DMemReady) state <= (inst_class == C_STORE) ? S_FETCH : S_WB;
        S_WB:     state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_HALT;
      endcase
    end
  end

  // output decode; gated by rst so in-flight enables drop as soon as reset hits
  always_comb begin
    IMemReq  = 1'b0;
    IrWrite  = 1'b0;
    PcWrite  = 1'b0;
    PcInit   = 1'b0;
    PcSrc    = PC_PLUS4;
    AluSrcA  = 1'b0;
    AluSrcB  = 1'b0;
    ImmType  = IMM_NONE;
    DMemReq  = 1'b0;
    DMemWe   = 1'b0;
    RegWrite = 1'b0;
    WbSel    = WB_ALU;
    Halt     = 1'b0;
    if (!rst) begin
      case (state)
        S_INIT: begin
          PcInit  = 1'b1;
          PcWrite = 1'b1;
        end
        S_FETCH: begin
          IMemReq = 1'b1;
          if (IMemReady) begin
            IrWrite = 1'b1;
            PcWrite = 1'b1;
            PcSrc   = PC_PLUS4;
          end
        end
        S_DECODE: ImmType = dec_imm;
        S_EXEC: begin
          ImmType = dec_imm;
          AluSrcA = alu_a;
          AluSrcB = alu_b;
          case (inst_class)
            C_BRANCH: begin PcWrite = BranchTaken; PcSrc = PC_BRANCH; end
            C_JAL:    begin PcWrite = 1'b1;        PcSrc = PC_BRANCH; end
            C_JALR:   begin PcWrite = 1'b1;        PcSrc = PC_ALU;    end
            default: ;
          endcase
        end
        S_MEM: begin
          ImmType = dec_imm;
          AluSrcA = alu_a;
          AluSrcB = alu_b;
          DMemReq = 1'b1;
          DMemWe  = (inst_class == C_STORE);
        end
        S_WB: begin
          ImmType  = dec_imm;
          AluSrcA  = alu_a;
          AluSrcB  = alu_b;
          RegWrite = 1'b1;
          case (inst_class)
            C_LOAD:        WbSel = WB_MEM;
            C_JAL, C_JALR: WbSel = WB_PC4;
            default:       WbSel = WB_ALU;
          endcase
        end
        S_HALT:  Halt = 1'b1;
        default: ;
      endcase
    end
  end

  assign State = state;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic retire;
  assign retire = (state == S_WB)
                | (state == S_MEM  && DMemReady && inst_class == C_STORE)
                | (state == S_EXEC && inst_class == C_BRANCH);

  // active-cycle and retired-instruction counters, free-running modulo 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CycleCnt   <= 32'd0;
      InstRetCnt <= 32'd0;
    end else begin
      if (state != S_INIT && state != S_HALT) CycleCnt <= CycleCnt + 32'd1;
      if (retire) InstRetCnt <= InstRetCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] Instruction;
  logic        IMemReady, DMemReady, BranchTaken;
  logic        IMemReq, IrWrite, PcWrite, PcInit;
  logic [1:0]  PcSrc;
  logic        AluSrcA, AluSrcB;
  imm_type_t   ImmType;
  logic        DMemReq, DMemWe, RegWrite;
  logic [1:0]  WbSel;
  logic        Halt;
  logic [2:0]  State;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] CycleCnt, InstRetCnt;
`endif

  multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .Instruction(Instruction),
    .IMemReady(IMemReady), .DMemReady(DMemReady), .BranchTaken(BranchTaken),
    .IMemReq(IMemReq), .IrWrite(IrWrite), .PcWrite(PcWrite), .PcInit(PcInit),
    .PcSrc(PcSrc), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .ImmType(ImmType),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .RegWrite(RegWrite), .WbSel(WbSel),
    .Halt(Halt), .State(State)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .CycleCnt(CycleCnt), .InstRetCnt(InstRetCnt)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic       imreq, irw, pcw, pcinit;
    logic [1:0] pcsrc;
    logic       asa, asb;
    logic [2:0] imm;
    logic       dreq, dwe, rw;
    logic [1:0] wbsel;
    logic       halt;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t e_base(input logic [2:0] st, input logic [2:0] imm);
    exp_t e;
    e = '0;
    e.st = st;
    e.imm = imm;
    return e;
  endfunction

  function automatic exp_t e_init();
    exp_t e;
    e = e_base(S_INIT, IMM_NONE);
    e.pcinit = 1'b1;
    e.pcw = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic rdy);
    exp_t e;
    e = e_base(S_FETCH, IMM_NONE);
    e.imreq = 1'b1;
    e.irw = rdy;
    e.pcw = rdy;
    return e;
  endfunction

  function automatic exp_t e_exec(input logic [2:0] imm, input logic asa, input logic asb,
                                  input logic pcw, input logic [1:0] pcsrc);
    exp_t e;
    e = e_base(S_EXEC, imm);
    e.asa = asa;
    e.asb = asb;
    e.pcw = pcw;
    e.pcsrc = pcsrc;
    return e;
  endfunction

  function automatic exp_t e_mem(input logic [2:0] imm, input logic we);
    exp_t e;
    e = e_base(S_MEM, imm);
    e.dreq = 1'b1;
    e.dwe = we;
    return e;
  endfunction

  function automatic exp_t e_wb(input logic [2:0] imm, input logic [1:0] wbsel);
    exp_t e;
    e = e_base(S_WB, imm);
    e.rw = 1'b1;
    e.wbsel = wbsel;
    return e;
  endfunction

  function automatic exp_t e_halt();
    exp_t e;
    e = e_base(S_HALT, IMM_NONE);
    e.halt = 1'b1;
    return e;
  endfunction

  // one clock: drive inputs, queue expectation, compare at negedge, advance
  task automatic cyc(input string tag, input logic imr, input logic dmr, input logic bt,
                     input exp_t e, input logic m_alu, input logic m_imm);
    exp_t got, want, msk;
    string t;
    IMemReady = imr;
    DMemReady = dmr;
    BranchTaken = bt;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    got = '{State, IMemReq, IrWrite, PcWrite, PcInit, PcSrc, AluSrcA, AluSrcB,
            ImmType, DMemReq, DMemWe, RegWrite, WbSel, Halt};
    want = sb_q.pop_front();
    t = tag_q.pop_front();
    msk = '1;
    if (m_alu) begin msk.asa = 1'b0; msk.asb = 1'b0; end
    if (m_imm) msk.imm = 3'b000;
    checks++;
    assert ((got & msk) === (want & msk)) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, got & msk, want & msk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    Instruction = 32'h0;
    IMemReady = 1'b0;
    DMemReady = 1'b0;
    BranchTaken = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", 1, 1, 1, e_base(S_INIT, IMM_NONE), 0, 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    checks++;
    assert (CycleCnt === 32'd0 && InstRetCnt === 32'd0) else begin
      errors++;
      $error("FAIL perf_reset observed=%h/%h expected=0/0", CycleCnt, InstRetCnt);
    end
`endif
    rst = 1'b0;

    // ADDI x1,x0,5 with zero-wait memory: PcInit c1, IrWrite c2, RegWrite c5
    cyc("addi_c1_init", 0, 0, 0, e_init(), 0, 0);
    Instruction = 32'h00500093;
    cyc("addi_c2_fetch", 1, 0, 0, e_fetch(1), 0, 1);
    cyc("addi_c3_dec", 0, 0, 0, e_base(S_DECODE, IMM_I), 0, 0);
    cyc("addi_c4_exec", 0, 0, 0, e_exec(IMM_I, 0, 1, 0, PC_PLUS4), 0, 0);
    cyc("addi_c5_wb", 0, 0, 0, e_wb(IMM_I, WB_ALU), 1, 0);

    // LW with one fetch wait and DMemReady three cycles late
    Instruction = 32'h0000A103;
    cyc("lw_fetch_wait", 0, 1, 0, e_fetch(0), 0, 1);
    cyc("lw_fetch", 1, 0, 0, e_fetch(1), 0, 1);
    cyc("lw_dec", 0, 1, 0, e_base(S_DECODE, IMM_I), 0, 0);
    cyc("lw_exec", 1, 1, 0, e_exec(IMM_I, 0, 1, 0, PC_PLUS4), 0, 0);
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1, 0, 0, e_mem(IMM_I, 0), 1, 0);
    cyc("lw_mem_done", 0, 1, 0, e_mem(IMM_I, 0), 1, 0);
    cyc("lw_wb", 0, 0, 0, e_wb(IMM_I, WB_MEM), 1, 0);

    // BEQ taken then not taken, 3 cycles each
    Instruction = 32'h00000463;
    cyc("beq1_fetch", 1, 0, 0, e_fetch(1), 0, 1);
    cyc("beq1_dec", 0, 0, 0, e_base(S_DECODE, IMM_B), 0, 0);
    cyc("beq1_exec_taken", 0, 0, 1, e_exec(IMM_B, 0, 0, 1, PC_BRANCH), 0, 0);
    cyc("beq2_fetch", 1, 0, 0, e_fetch(1), 0, 1);
    cyc("beq2_dec", 0, 0, 1, e_base(S_DECODE, IMM_B), 0, 0);
    cyc("beq2_exec_not", 0, 0, 0, e_exec(IMM_B, 0, 0, 0, PC_BRANCH), 0, 0);

    // JALR x1,0(x1)
    Instruction = 32'h000080E7;
    cyc("jalr_fetch", 1, 0, 0, e_fetch(1), 0, 1);
    cyc("jalr_dec", 0, 0, 0, e_base(S_DECODE, IMM_I), 0, 0);
    cyc("jalr_exec", 0, 0, 0, e_exec(IMM_I, 0, 1, 1, PC_ALU), 0, 0);
    cyc("jalr_wb", 0, 0, 0, e_wb(IMM_I, WB_PC4), 1, 0);

    // JAL x0,8
    Instruction = 32'h0080006F;
    cyc("jal_fetch", 1, 0, 0, e_fetch(1), 0, 1);
    cyc("jal_dec", 0, 0, 0, e_base(S_DECODE, IMM_J), 0, 0);
    cyc("jal_exec", 0, 0, 0, e_exec(IMM_J, 0, 0, 1, PC_BRANCH), 0, 0);
    cyc("jal_wb", 0, 0, 0, e_wb(IMM_J, WB_PC4), 1, 0);

    // AUIPC x1,1
    Instruction = 32'h00001097;
    cyc("auipc_fetch", 1, 0, 0, e_fetch(1), 0, 1);
    cyc("auipc_dec", 0, 0, 0, e_base(S_DECODE, IMM_U), 0, 0);
    cyc("auipc_exec", 0, 0, 0, e_exec(IMM_U, 1, 1, 0, PC_PLUS4), 0, 0);
    cyc("auipc_wb", 0, 0, 0, e_wb(IMM_U, WB_ALU), 1, 0);

    // SW zero-wait: 4 cycles, store retires in MEM
    Instruction = 32'h00112023;
    cyc("sw_fetch", 1, 0, 0, e_fetch(1), 0, 1);
    cyc("sw_dec", 0, 0, 0, e_base(S_DECODE, IMM_S), 0, 0);
    cyc("sw_exec", 0, 0, 0, e_exec(IMM_S, 0, 1, 0, PC_PLUS4), 0, 0);
    cyc("sw_mem", 0, 1, 0, e_mem(IMM_S, 1), 1, 0);

    // second store; reset lands in the middle of its MEM wait
    cyc("sw2_fetch", 1, 0, 0, e_fetch(1), 0, 1);
    cyc("sw2_dec", 0, 0, 0, e_base(S_DECODE, IMM_S), 0, 0);
    cyc("sw2_exec", 0, 0, 0, e_exec(IMM_S, 0, 1, 0, PC_PLUS4), 0, 0);
    cyc("sw2_mem_wait", 0, 0, 0, e_mem(IMM_S, 1), 1, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    assert (DMemReq === 1'b0 && State === 3'(S_INIT)) else begin
      errors++;
      $error("FAIL async_rst observed=req%b st%0d expected=req0 st%0d", DMemReq, State, S_INIT);
    end
    @(posedge clk);
    #1;
    cyc("rst_hold", 0, 1, 0, e_base(S_INIT, IMM_NONE), 0, 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    checks++;
    assert (CycleCnt === 32'd0 && InstRetCnt === 32'd0) else begin
      errors++;
      $error("FAIL perf_after_rst observed=%h/%h expected=0/0", CycleCnt, InstRetCnt);
    end
`endif
    rst = 1'b0;
    cyc("restart_init", 0, 0, 0, e_init(), 0, 0);

    // illegal opcode halts; nothing moves for 20 cycles
    Instruction = 32'hFFFFFFFF;
    cyc("ill_fetch", 1, 0, 0, e_fetch(1), 0, 1);
    cyc("ill_dec", 0, 0, 0, e_base(S_DECODE, IMM_NONE), 0, 0);
    for (int i = 0; i < 20; i++) begin
      logic b;
      b = i[0];
      cyc("halt_hold", b, ~b, b, e_halt(), 0, 0);
    end
    rst = 1'b1;
    #1;
    cyc("halt_rst", 0, 0, 0, e_base(S_INIT, IMM_NONE), 0, 0);
    rst = 1'b0;
    cyc("halt_reinit", 0, 0, 0, e_init(), 0, 0);
    cyc("halt_refetch", 0, 0, 0, e_fetch(0), 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
